// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared defaults and elaboration helpers for sync_fifo_param.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // One extra bit over the index width serves as the wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int depth, input int af_level, input int ae_level);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module   : fifo_ram
// Brief    : Simple dual-port storage, synchronous write and registered read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // The array itself is never reset; only the output register is.
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module   : sync_fifo_param
// Brief    : Parametrised single-clock FIFO with occupancy count, almost
//            flags and optional sticky overflow/underflow (SYNC_FIFO_ERR_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [WIDTH-1:0]            DATAIN,
    input  logic                        wn,
    input  logic                        rn,
    output logic [WIDTH-1:0]            DATAOUT,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [ptr_width(DEPTH)-1:0] count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                        overflow,
    output logic                        underflow
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] c_AF_LEVEL = PW'(AF_LEVEL);
    localparam logic [PW-1:0] c_AE_LEVEL = PW'(AE_LEVEL);

    generate
        if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
            $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
        end
    endgenerate

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_ok;
    logic          w_rd_ok;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    // Acceptance uses pre-edge flags, so full+wn+rn reads and empty+wn+rn writes.
    assign w_wr_ok = wn & ~w_full;
    assign w_rd_ok = rn & ~w_empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + PW'(1);
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - PW'(1);
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (w_wr_ok),
        .waddr   (r_wptr[AW-1:0]),
        .wdata   (DATAIN),
        .re      (w_rd_ok),
        .raddr   (r_rptr[AW-1:0]),
        .rdata   (DATAOUT)
    );

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = r_count;
    assign almost_full  = (r_count >= c_AF_LEVEL);
    assign almost_empty = (r_count <= c_AE_LEVEL);

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wn && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rn && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, successor to the fixed 8x8 synchronous FIFO. Generalised in data width and depth. Adds:
- simultaneous read and write in one cycle;
- full use of all DEPTH entries;
- an occupancy count and programmable almost-full/almost-empty flags;
- optional sticky overflow/underflow error flags.

It sits between any producer/consumer pair sharing one clock.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- DATAIN  in  WIDTH  write data
- wn  in  1  write request
- rn  in  1  read request
- DATAOUT  out  WIDTH  registered read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; only present with SYNC_FIFO_ERR_EN
- underflow  out  1  sticky; only present with SYNC_FIFO_ERR_EN

## Operation
- **Pointers:** wptr and rptr are $clog2(DEPTH)+1 bits each; the MSB is the wrap bit.
  - empty: pointers are fully equal.
  - full: index bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- **Write accepted** (wr_ok = wn & !full): mem[wptr index] <= DATAIN; wptr++.
- **Read accepted** (rd_ok = rn & !empty): DATAOUT <= mem[rptr index]; rptr++.
- **Read and write are independent.** Both may be accepted in the same cycle.
- **Count update:** +1 on write only, -1 on read only, unchanged when both are accepted.
- **Simultaneous wn & rn while full:** the read is accepted and the write is rejected, because full is evaluated on pre-edge state. Result: count drops to DEPTH-1.
- **Simultaneous wn & rn while empty:** the write is accepted and the read is rejected. DATAOUT is unchanged and count becomes 1.
- **Rejected requests** (write while full, read while empty) change no state, apart from the error flags when SYNC_FIFO_ERR_EN is defined.
- **DATAOUT hold:** DATAOUT holds its value until the next accepted read.
- **Memory contents** are not reset; only pointers, count, DATAOUT and flags are.
- **Flag sources:**
  - full, empty, almost_full and almost_empty are combinational from registered count/pointers. They have no path from wn/rn.
  - count is a register, not a pointer difference.

## Timing
- **Reset** (reset_n low, asynchronous, at any time including mid-transfer):
  - wptr = rptr = 0, count = 0, DATAOUT = 0, overflow = underflow = 0;
  - therefore full = 0, empty = 1, almost_empty = 1;
  - almost_full = 0 unless AF_LEVEL == 0.
- **Reset release** is assumed synchronised externally. The first accepted write may occur on the first rising edge after deassertion.
- **Read latency:** 1 cycle. Data requested with rn at edge N appears on DATAOUT after edge N.
- **Write-to-read latency:** a word written at edge N causes empty to fall after edge N. It can be read at edge N+1 and appears on DATAOUT after N+1.
- **Flag latency:** all flags and count reflect the accepted operations of edge N immediately after edge N.
- **Throughput:** one write and one read per cycle sustained, at any fill level except the boundary cases above.

## Configuration
- **Macro:** SYNC_FIFO_ERR_EN.
- **Defined:**
  - overflow and underflow ports exist.
  - overflow sets on any edge with wn & full.
  - underflow sets on any edge with rn & empty.
  - Both flags stay set until reset_n is asserted.
- **Not defined:** neither port nor its register exists. Rejected requests are silently dropped, and all other behaviour is identical.

## Structure
- **Package fifo_pkg:**
  - function ptr_width(depth) = $clog2(depth)+1;
  - localparam-style defaults DEF_WIDTH = 8, DEF_DEPTH = 8;
  - an elaboration check function asserting DEPTH is a power of two and AE_LEVEL < AF_LEVEL <= DEPTH.
- **Sub-module fifo_ram:**
  - parameters WIDTH, DEPTH;
  - write port: clock, we, waddr, wdata;
  - synchronous read port: re, raddr, rdata registered;
  - no reset on the array.
- **Top level** holds the pointers, count, flags and the optional error logic.

## Test plan
- Reset, then write 0x11..0x88 into DEPTH=8, WIDTH=8 → full=1 after the 8th edge, count=8. Read 8 → DATAOUT 0x11..0x88 in order, empty=1.
- While full, assert wn with DATAIN=0xFF → write rejected, count stays 8, data unchanged. With SYNC_FIFO_ERR_EN, overflow=1 and stays 1 after further traffic.
- At count=3, assert wn & rn for 20 cycles with incrementing data → count stays 3, pointers wrap, output order is preserved.
- Empty FIFO, wn & rn together with DATAIN=0x5A → count=1, DATAOUT unchanged. Next rn → DATAOUT=0x5A.
- AF_LEVEL=6, AE_LEVEL=2: fill one word at a time →
  - almost_empty deasserts at count=3;
  - almost_full asserts at count=6.
- Assert reset_n low asynchronously mid-burst at count=5 → all outputs return to reset values immediately, without waiting for a clock edge. Then write 0xA5 and read it back → DATAOUT=0xA5.
